// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/load-store memory port arbiter.
// Holds the state encoding, grant owners and watchdog sizing helper.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    BUSY_INST = 2'd1,
    BUSY_DATA = 2'd2
  } state_e;

  localparam logic INST = 1'b0;
  localparam logic DATA = 1'b1;

  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

  // Counter must reach TIMEOUT_CYCLES-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-requester round-robin picker owning the last-grant register.
// Grants only when enabled; a tie goes to the side not served last.
module rr_arbiter2
  import mem_port_arbiter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic req_inst_i,
  input  logic req_data_i,
  output logic gnt_o,
  output logic owner_o
);

  logic last_q;
  logic last_d;

  always_comb begin
    gnt_o   = 1'b0;
    owner_o = INST;
    last_d  = last_q;
    if (en_i) begin
      unique case ({req_data_i, req_inst_i})
        2'b01: begin
          gnt_o   = 1'b1;
          owner_o = INST;
        end
        2'b10: begin
          gnt_o   = 1'b1;
          owner_o = DATA;
        end
        2'b11: begin
          gnt_o   = 1'b1;
          owner_o = ~last_q;
        end
        default: begin
          gnt_o   = 1'b0;
          owner_o = INST;
        end
      endcase
      if (gnt_o) begin
        last_d = owner_o;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= INST;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and load/store.
// One transaction at a time, round-robin on conflict, sticky watchdog.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ip_inst_req,
  input  logic [ADDR_WIDTH-1:0]   ip_inst_addr,
  output logic                    op_inst_valid,
  output logic [DATA_WIDTH-1:0]   op_inst_data,
  input  logic                    ip_data_rd,
  input  logic                    ip_data_wr,
  input  logic [ADDR_WIDTH-1:0]   ip_data_addr,
  input  logic [DATA_WIDTH/8-1:0] ip_data_mask,
  input  logic [DATA_WIDTH-1:0]   ip_data_wdata,
  output logic                    op_data_valid,
  output logic [DATA_WIDTH-1:0]   op_data_rdata,
  output logic                    op_mem_req,
  output logic                    op_mem_wr,
  output logic [ADDR_WIDTH-1:0]   op_mem_addr,
  output logic [DATA_WIDTH/8-1:0] op_mem_mask,
  output logic [DATA_WIDTH-1:0]   op_mem_wdata,
  input  logic                    ip_mem_valid,
  input  logic [DATA_WIDTH-1:0]   ip_mem_rdata,
  output logic                    op_timeout
);

  localparam int unsigned MW = DATA_WIDTH / 8;
  localparam int unsigned CW = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);
  localparam logic WD_EN = (TIMEOUT_CYCLES != 0);

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [MW-1:0]         mask_q, mask_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  to_q, to_d;

  logic                  arb_en;
  logic                  gnt;
  logic                  owner;
  logic                  wd_hit;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  assign arb_en = (state_q == IDLE);
  assign wd_hit = WD_EN && (cnt_q == CNT_LAST);

  rr_arbiter2 u_rr (
    .clk        (clk),
    .reset      (reset),
    .en_i       (arb_en),
    .req_inst_i (ip_inst_req),
    .req_data_i (ip_data_rd | ip_data_wr),
    .gnt_o      (gnt),
    .owner_o    (owner)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    mask_d    = mask_q;
    wdata_d   = wdata_q;
    to_d      = to_q;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    unique case (state_q)
      IDLE: begin
        if (gnt) begin
          cnt_d = '0;
          if (owner == DATA) begin
            state_d = BUSY_DATA;
            wr_d    = ip_data_wr;
            addr_d  = ip_data_addr;
            mask_d  = ip_data_mask;
            wdata_d = ip_data_wdata;
          end else begin
            state_d = BUSY_INST;
            wr_d    = 1'b0;
            addr_d  = ip_inst_addr;
            mask_d  = '1;
            wdata_d = '0;
          end
        end
      end
      BUSY_INST, BUSY_DATA: begin
        if (ip_mem_valid) begin
          rsp_valid = 1'b1;
          rsp_data  = ip_mem_rdata;
          state_d   = IDLE;
          cnt_d     = '0;
        end else if (wd_hit) begin
          // Abort with a zero word so the core can retire and trap.
          rsp_valid = 1'b1;
          to_d      = 1'b1;
          state_d   = IDLE;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign op_inst_valid = rsp_valid && (state_q == BUSY_INST);
  assign op_data_valid = rsp_valid && (state_q == BUSY_DATA);
  assign op_inst_data  = (state_q == BUSY_INST) ? rsp_data : '0;
  assign op_data_rdata = (state_q == BUSY_DATA) ? rsp_data : '0;

  assign op_mem_req   = (state_q != IDLE);
  assign op_mem_wr    = wr_q;
  assign op_mem_addr  = addr_q;
  assign op_mem_mask  = mask_q;
  assign op_mem_wdata = wdata_q;
  assign op_timeout   = to_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      wdata_q <= wdata_d;
      to_q    <= to_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a response scoreboard.
// Watchdog shortened to 4 cycles so the abort path is reachable.
module tb_mem_port_arbiter;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  typedef struct {
    logic        owner;
    logic        chk_data;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        ip_inst_req;
  logic [31:0] ip_inst_addr;
  logic        op_inst_valid;
  logic [31:0] op_inst_data;
  logic        ip_data_rd;
  logic        ip_data_wr;
  logic [31:0] ip_data_addr;
  logic [3:0]  ip_data_mask;
  logic [31:0] ip_data_wdata;
  logic        op_data_valid;
  logic [31:0] op_data_rdata;
  logic        op_mem_req;
  logic        op_mem_wr;
  logic [31:0] op_mem_addr;
  logic [3:0]  op_mem_mask;
  logic [31:0] op_mem_wdata;
  logic        ip_mem_valid;
  logic [31:0] ip_mem_rdata;
  logic        op_timeout;

  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  mem_port_arbiter #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ip_inst_req   (ip_inst_req),
    .ip_inst_addr  (ip_inst_addr),
    .op_inst_valid (op_inst_valid),
    .op_inst_data  (op_inst_data),
    .ip_data_rd    (ip_data_rd),
    .ip_data_wr    (ip_data_wr),
    .ip_data_addr  (ip_data_addr),
    .ip_data_mask  (ip_data_mask),
    .ip_data_wdata (ip_data_wdata),
    .op_data_valid (op_data_valid),
    .op_data_rdata (op_data_rdata),
    .op_mem_req    (op_mem_req),
    .op_mem_wr     (op_mem_wr),
    .op_mem_addr   (op_mem_addr),
    .op_mem_mask   (op_mem_mask),
    .op_mem_wdata  (op_mem_wdata),
    .ip_mem_valid  (ip_mem_valid),
    .ip_mem_rdata  (ip_mem_rdata),
    .op_timeout    (op_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard side: every valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (op_inst_valid || op_data_valid) begin
      if (sb.size() == 0) begin
        chk("stray_valid", {30'd0, op_inst_valid, op_data_valid}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_owner", {31'd0, op_data_valid}, {31'd0, e.owner});
        chk("sb_one_hot", {31'd0, op_inst_valid & op_data_valid}, 32'd0);
        if (e.chk_data) begin
          chk("sb_data", e.owner ? op_data_rdata : op_inst_data, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    logic [31:0] f_addr [3];
    logic [31:0] f_data [3];
    logic        f_own  [3];
    n_chk = 0;
    n_fail = 0;
    reset = 1'b0;
    ip_inst_req = 1'b0;
    ip_inst_addr = '0;
    ip_data_rd = 1'b0;
    ip_data_wr = 1'b0;
    ip_data_addr = '0;
    ip_data_mask = '0;
    ip_data_wdata = '0;
    ip_mem_valid = 1'b0;
    ip_mem_rdata = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", {31'd0, op_mem_req}, 32'd0);
    chk("rst_wr", {31'd0, op_mem_wr}, 32'd0);
    chk("rst_addr", op_mem_addr, 32'd0);
    chk("rst_mask", {28'd0, op_mem_mask}, 32'd0);
    chk("rst_wdata", op_mem_wdata, 32'd0);
    chk("rst_to", {31'd0, op_timeout}, 32'd0);
    chk("rst_iv", {31'd0, op_inst_valid}, 32'd0);
    chk("rst_dv", {31'd0, op_data_valid}, 32'd0);

    // Single fetch, memory answers on the 3rd busy cycle
    @(negedge clk);
    reset = 1'b1;
    ip_inst_req = 1'b1;
    ip_inst_addr = 32'h0000_0010;
    sb.push_back('{OWN_I, 1'b1, 32'h0050_0093});
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("f_req", {31'd0, op_mem_req}, 32'd1);
      chk("f_wr", {31'd0, op_mem_wr}, 32'd0);
      chk("f_addr", op_mem_addr, 32'h0000_0010);
      chk("f_mask", {28'd0, op_mem_mask}, 32'hF);
      chk("f_iv_wait", {31'd0, op_inst_valid}, 32'd0);
    end
    @(negedge clk);
    ip_mem_valid = 1'b1;
    ip_mem_rdata = 32'h0050_0093;
    #1;
    chk("f_req3", {31'd0, op_mem_req}, 32'd1);
    chk("f_iv", {31'd0, op_inst_valid}, 32'd1);
    chk("f_data", op_inst_data, 32'h0050_0093);
    @(negedge clk);
    ip_mem_valid = 1'b0;
    ip_inst_req = 1'b0;
    #1;
    chk("f_req_done", {31'd0, op_mem_req}, 32'd0);
    chk("f_iv_done", {31'd0, op_inst_valid}, 32'd0);

    // Store acknowledged in the first busy cycle
    ip_data_wr = 1'b1;
    ip_data_addr = 32'h0000_0100;
    ip_data_mask = 4'b0011;
    ip_data_wdata = 32'hDEAD_BEEF;
    sb.push_back('{OWN_D, 1'b0, 32'd0});
    @(negedge clk);
    ip_mem_valid = 1'b1;
    ip_mem_rdata = 32'hBAD0_0BAD;
    #1;
    chk("s_req", {31'd0, op_mem_req}, 32'd1);
    chk("s_wr", {31'd0, op_mem_wr}, 32'd1);
    chk("s_addr", op_mem_addr, 32'h0000_0100);
    chk("s_mask", {28'd0, op_mem_mask}, 32'h3);
    chk("s_wdata", op_mem_wdata, 32'hDEAD_BEEF);
    chk("s_dv", {31'd0, op_data_valid}, 32'd1);
    chk("s_iv", {31'd0, op_inst_valid}, 32'd0);
    @(negedge clk);
    ip_mem_valid = 1'b0;
    ip_data_wr = 1'b0;
    #1;
    chk("s_req_done", {31'd0, op_mem_req}, 32'd0);
    chk("s_dv_done", {31'd0, op_data_valid}, 32'd0);

    // rd and wr together behave as a write
    ip_data_rd = 1'b1;
    ip_data_wr = 1'b1;
    ip_data_addr = 32'h0000_0200;
    ip_data_mask = 4'hF;
    ip_data_wdata = 32'h1234_5678;
    sb.push_back('{OWN_D, 1'b0, 32'd0});
    @(negedge clk);
    ip_mem_valid = 1'b1;
    #1;
    chk("rw_wr", {31'd0, op_mem_wr}, 32'd1);
    chk("rw_addr", op_mem_addr, 32'h0000_0200);
    chk("rw_wdata", op_mem_wdata, 32'h1234_5678);
    @(negedge clk);
    ip_mem_valid = 1'b0;
    ip_data_rd = 1'b0;
    ip_data_wr = 1'b0;

    // Load with a silent memory trips the watchdog
    ip_data_rd = 1'b1;
    ip_data_addr = 32'h0000_0300;
    ip_mem_rdata = 32'hFFFF_FFFF;
    sb.push_back('{OWN_D, 1'b1, 32'd0});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      #1;
      chk("t_req", {31'd0, op_mem_req}, 32'd1);
      chk("t_dv_wait", {31'd0, op_data_valid}, 32'd0);
      chk("t_flag_wait", {31'd0, op_timeout}, 32'd0);
    end
    @(negedge clk);
    #1;
    chk("t_dv", {31'd0, op_data_valid}, 32'd1);
    chk("t_rdata", op_data_rdata, 32'd0);
    chk("t_wr", {31'd0, op_mem_wr}, 32'd0);
    @(negedge clk);
    ip_data_rd = 1'b0;
    #1;
    chk("t_req_done", {31'd0, op_mem_req}, 32'd0);
    chk("t_flag", {31'd0, op_timeout}, 32'd1);
    @(negedge clk);
    ip_mem_valid = 1'b1;
    ip_mem_rdata = 32'h0000_CAFE;
    #1;
    chk("t_late_iv", {31'd0, op_inst_valid}, 32'd0);
    chk("t_late_dv", {31'd0, op_data_valid}, 32'd0);
    @(negedge clk);
    ip_mem_valid = 1'b0;
    #1;
    chk("t_sticky", {31'd0, op_timeout}, 32'd1);
    chk("t_idle", {31'd0, op_mem_req}, 32'd0);

    // Reset during a fetch, then a late memory response
    ip_inst_req = 1'b1;
    ip_inst_addr = 32'h0000_0040;
    @(negedge clk);
    #1;
    chk("r_busy", {31'd0, op_mem_req}, 32'd1);
    chk("r_addr_busy", op_mem_addr, 32'h0000_0040);
    reset = 1'b0;
    ip_inst_req = 1'b0;
    @(negedge clk);
    #1;
    chk("r_req", {31'd0, op_mem_req}, 32'd0);
    chk("r_wr", {31'd0, op_mem_wr}, 32'd0);
    chk("r_addr", op_mem_addr, 32'd0);
    chk("r_mask", {28'd0, op_mem_mask}, 32'd0);
    chk("r_wdata", op_mem_wdata, 32'd0);
    chk("r_to", {31'd0, op_timeout}, 32'd0);
    chk("r_iv", {31'd0, op_inst_valid}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    ip_mem_valid = 1'b1;
    ip_mem_rdata = 32'h0BAD_F00D;
    #1;
    chk("r_late_iv", {31'd0, op_inst_valid}, 32'd0);
    chk("r_late_req", {31'd0, op_mem_req}, 32'd0);
    @(negedge clk);
    ip_mem_valid = 1'b0;

    // Both requesters held: DATA, INST, DATA after reset
    f_addr[0] = 32'h0000_2000; f_own[0] = OWN_D; f_data[0] = 32'h1111_1111;
    f_addr[1] = 32'h0000_1000; f_own[1] = OWN_I; f_data[1] = 32'h2222_2222;
    f_addr[2] = 32'h0000_2000; f_own[2] = OWN_D; f_data[2] = 32'h3333_3333;
    ip_inst_req = 1'b1;
    ip_inst_addr = 32'h0000_1000;
    ip_data_rd = 1'b1;
    ip_data_addr = 32'h0000_2000;
    ip_data_mask = 4'hF;
    for (int r = 0; r < 3; r++) begin
      sb.push_back('{f_own[r], 1'b1, f_data[r]});
    end
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      ip_mem_valid = 1'b1;
      ip_mem_rdata = f_data[r];
      #1;
      chk("rr_req", {31'd0, op_mem_req}, 32'd1);
      chk("rr_addr", op_mem_addr, f_addr[r]);
      chk("rr_dv", {31'd0, op_data_valid}, {31'd0, f_own[r]});
      chk("rr_iv", {31'd0, op_inst_valid}, {31'd0, ~f_own[r]});
      @(negedge clk);
      ip_mem_valid = 1'b0;
      if (r == 2) begin
        ip_inst_req = 1'b0;
        ip_data_rd = 1'b0;
      end
      #1;
      chk("rr_gap", {31'd0, op_mem_req}, 32'd0);
    end
    @(negedge clk);
    #1;
    chk("rr_quiet", {31'd0, op_mem_req}, 32'd0);

    @(negedge clk);
    #3;
    chk("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified memory port between the core's instruction-fetch requester and its load/store requester.
- Sits between the rv32i core and a single-ported variable-latency memory.
- Grants one transaction at a time, using round-robin on conflict.
- Returns per-requester valid pulses and carries a watchdog so a hung memory cannot stall the core forever.

Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width; mask width is DATA_WIDTH/8
- TIMEOUT_CYCLES, 255, busy cycles without ip_mem_valid before abort; 0 disables the watchdog

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-low reset (asserted when 0)
- ip_inst_req  input  1  fetch request, held until op_inst_valid
- ip_inst_addr  input  ADDR_WIDTH  fetch address
- op_inst_valid  output  1  one-cycle fetch completion
- op_inst_data  output  DATA_WIDTH  fetched word, valid with op_inst_valid
- ip_data_rd  input  1  load request, held until op_data_valid
- ip_data_wr  input  1  store request, held until op_data_valid
- ip_data_addr  input  ADDR_WIDTH  load/store address
- ip_data_mask  input  DATA_WIDTH/8  byte-enable for stores
- ip_data_wdata  input  DATA_WIDTH  store data
- op_data_valid  output  1  one-cycle load/store completion
- op_data_rdata  output  DATA_WIDTH  load data, valid with op_data_valid
- op_mem_req  output  1  memory transaction active
- op_mem_wr  output  1  1 = write
- op_mem_addr  output  ADDR_WIDTH  registered address
- op_mem_mask  output  DATA_WIDTH/8  registered byte-enable
- op_mem_wdata  output  DATA_WIDTH  registered write data
- ip_mem_valid  input  1  memory completion, single cycle
- ip_mem_rdata  input  DATA_WIDTH  memory read data
- op_timeout  output  1  sticky watchdog error flag

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE, last_grant=INST, counter=0.
  - op_mem_req, op_mem_wr, op_inst_valid, op_data_valid and op_timeout = 0.
  - Address, mask and data registers = 0.
  - Any in-flight transaction is dropped; no valid is issued for it.
- States: IDLE, BUSY_INST, BUSY_DATA.
- IDLE:
  - data_pending = ip_data_rd | ip_data_wr.
  - If only one requester is pending, grant it.
  - If both are pending, grant the requester opposite last_grant.
  - On grant, latch addr/mask/wdata/wr into op_mem_* registers, update last_grant, clear the counter, and go to BUSY_x next cycle.
  - Instruction grants force wr=0 and mask=all ones.
  - If ip_data_rd and ip_data_wr are both 1, the request is treated as a write.
- op_mem_req = (state != IDLE). op_mem_* are stable for the whole BUSY period.
- BUSY_x with ip_mem_valid=1:
  - The requester's valid is asserted combinationally in the same cycle.
  - Its data output = ip_mem_rdata; for writes the data output is don't-care.
  - Next state = IDLE; the counter clears.
- BUSY_x without ip_mem_valid:
  - The counter increments.
  - When counter == TIMEOUT_CYCLES-1 (and TIMEOUT_CYCLES != 0), the requester's valid pulses with data output 0, op_timeout is set (sticky until reset), and next state = IDLE.
- ip_mem_valid in IDLE is ignored, which covers late responses after a timeout or reset.
- Minimum latency: request seen in IDLE at cycle N, op_mem_req high at N+1, valid at N+1 if memory answers immediately. Back-to-back throughput is one transaction per 2 cycles.
- Valid outputs are 0 whenever they are not owned by the current BUSY state. Both valids are never high together.
- Requester obligation: drop or replace the request in the cycle after its valid. A request still held in IDLE is treated as a new transaction.

Decomposition:
- Shared package:
  - state encoding (IDLE=2'd0, BUSY_INST=2'd1, BUSY_DATA=2'd2)
  - grant-owner constants (INST=1'b0, DATA=1'b1)
  - default TIMEOUT_CYCLES
- One natural sub-module: rr_arbiter2, a two-requester round-robin picker with the last_grant register.
- The watchdog counter stays inline.

Test Plan:
- Single fetch:
  - Stimulus: ip_inst_req=1, addr=32'h0000_0010; memory returns 32'h0050_0093 after 3 cycles.
  - Required: op_mem_req high 3 cycles, op_mem_wr=0, op_inst_valid pulses once with 32'h0050_0093.
- Store:
  - Stimulus: ip_data_wr=1, addr=32'h0000_0100, mask=4'b0011, wdata=32'hDEAD_BEEF; memory acks in the same cycle.
  - Required: op_mem_wr=1, mask=4'b0011, op_data_valid one cycle, op_inst_valid stays 0.
- Conflict fairness, three rounds:
  - Stimulus: fetch and load held continuously after reset.
  - Required: grant order DATA, INST, DATA, with exactly one valid per BUSY period.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=4, load issued, memory never responds.
  - Required: op_data_valid on the 4th BUSY cycle with rdata=0, op_timeout=1 and sticky.
  - Required: a later stray ip_mem_valid in IDLE produces no valid.
- Reset mid-transaction:
  - Stimulus: reset=0 during BUSY_INST, then ip_mem_valid=1 the cycle after reset is released.
  - Required: all outputs 0, state IDLE, no op_inst_valid.
- rd+wr both high:
  - Stimulus: ip_data_rd=1 and ip_data_wr=1 together.
  - Required: op_mem_wr=1.
